// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer: qualification FSM state encoding.
package debounce_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        QUALIFY = 1'b1
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-edge latency, resets to 0.
// No backpressure; the input is sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw input; dout changes DEBOUNCE_CYCLES+2 edges after a clean din edge.
// No backpressure. Rise/fall pulse outputs are built only with DEBOUNCE_PULSE_EN defined.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             din_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             busy_q, busy_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (din_s != dout_q) begin
                    // With a one-cycle window the first differing edge already qualifies.
                    if (CNT_LAST == '0) begin
                        dout_d = ~dout_q;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            QUALIFY: begin
                if (din_s == dout_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    dout_d  = ~dout_q;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == QUALIFY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_PULSE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulses are registered alongside dout so they line up with its new value.
    always_comb begin
        rise_d = dout_d & ~dout_q;
        fall_d = ~dout_d & dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (DEBOUNCE_CYCLES=4) with an output-event scoreboard.
module tb_input_debouncer;

    localparam int N   = 4;
    localparam int LAT = N + 2;
`ifdef DEBOUNCE_PULSE_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    typedef struct {
        int   cyc;
        logic dout;
        logic rise;
        logic fall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic dout, rise, fall, busy;

    exp_t sb[$];
    int   cyc       = 0;
    int   tests     = 0;
    int   fails     = 0;
    logic prev_dout = 1'b0;
    logic busy_seen;

    input_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic d, input logic r, input logic f);
        exp_t e;
        e.cyc  = c;
        e.dout = d;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    // Advance one edge, then match any output event against the scoreboard.
    task automatic tick();
        exp_t e;
        logic ev;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            tests++;
            assert (sb[0].cyc >= cyc) else begin
                fails++;
                $error("FAIL missed_event: now cycle %0d, expected event at cycle %0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
        ev = (dout !== prev_dout) || (rise !== 1'b0) || (fall !== 1'b0);
        if (ev) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_event: cycle %0d dout %b rise %b fall %b, expected no event",
                       cyc, dout, rise, fall);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_int("event_cycle", cyc, e.cyc);
                check("event_dout", dout, e.dout);
                check("event_rise", rise, e.rise);
                check("event_fall", fall, e.fall);
            end
        end
        check("rise_fall_exclusive", rise & fall, 1'b0);
        prev_dout = dout;
    endtask

    initial begin
        rst = 1'b0;
        din = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("reset_async_dout", dout, 1'b0);
        check("reset_async_rise", rise, 1'b0);
        check("reset_async_fall", fall, 1'b0);
        check("reset_async_busy", busy, 1'b0);

        // Reset held with din high: nothing may move.
        din = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("reset_held_dout", dout, 1'b0);
        check("reset_held_busy", busy, 1'b0);
        check("reset_held_rise", rise, 1'b0);

        // Release with din already high: rise at the 6th edge.
        rst = 1'b0;
        push(cyc + LAT, 1'b1, PE, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("first_rise_busy", busy, (i >= 3 && i <= 5));
        end
        check("first_rise_dout", dout, 1'b1);

        // Clean fall.
        din = 1'b0;
        push(cyc + LAT, 1'b0, 1'b0, PE);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("fall_busy", busy, (i >= 3 && i <= 5));
        end
        check("fall_dout", dout, 1'b0);

        // Glitch of N-1 cycles must be rejected.
        busy_seen = 1'b0;
        din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            busy_seen |= busy;
        end
        din = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            busy_seen |= busy;
        end
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_dout", dout, 1'b0);
        check("glitch_busy_end", busy, 1'b0);

        // Bounce 1,0,1,0 then hold 1.
        din = 1'b1; tick();
        din = 1'b0; tick();
        din = 1'b1; tick();
        din = 1'b0; tick();
        din = 1'b1;
        push(cyc + LAT, 1'b1, PE, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("bounce_dout", dout, 1'b1);

        din = 1'b0;
        push(cyc + LAT, 1'b0, 1'b0, PE);
        for (int i = 0; i < 8; i++) tick();
        check("bounce_fall_dout", dout, 1'b0);

        // Reset in the middle of qualification (count 2).
        din = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("midq_busy_before", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("midq_reset_dout", dout, 1'b0);
        check("midq_reset_busy", busy, 1'b0);
        check("midq_reset_rise", rise, 1'b0);
        for (int i = 0; i < 2; i++) tick();
        rst = 1'b0;
        push(cyc + LAT, 1'b1, PE, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("midq_after_dout", dout, 1'b1);

        // Asynchronous reset must clear a high dout without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("async_reset_dout_high", dout, 1'b0);
        check("async_reset_fall", fall, 1'b0);
        prev_dout = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        rst = 1'b0;
        din = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("final_dout", dout, 1'b0);

        check_int("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before the output changes; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port din, input, 1, raw asynchronous input (button or switch) feeding the downstream D flip-flop stage.
REQ-005 SHALL have port dout, output, 1, debounced registered level, the D input of the next stage.
REQ-006 SHALL have port rise, output, 1, one-cycle pulse when dout goes 0->1.
REQ-007 SHALL have port fall, output, 1, one-cycle pulse when dout goes 1->0.
REQ-008 SHALL have port busy, output, 1, high while a candidate change is being qualified.

Function
REQ-009 SHALL pass din through a two-flop synchronizer; the second-flop output is din_s.
REQ-010 SHALL implement FSM states IDLE (din_s == dout) and QUALIFY (din_s != dout).
REQ-011 IDLE -> QUALIFY on the first edge where din_s != dout; the counter loads 1.
REQ-012 In QUALIFY, the counter SHALL increment each edge while din_s != dout.
REQ-013 In QUALIFY, if din_s == dout, the FSM SHALL return to IDLE, clear the counter, and leave dout unchanged (glitch rejected).
REQ-014 When din_s has differed from dout for DEBOUNCE_CYCLES consecutive edges, dout SHALL toggle on that edge, the counter SHALL clear, and the FSM SHALL return to IDLE.
REQ-015 Latency from a clean din transition to the dout change SHALL be exactly DEBOUNCE_CYCLES+2 clock edges.
REQ-016 A pulse of DEBOUNCE_CYCLES-1 cycles or shorter (after synchronization) SHALL never change dout.
REQ-017 rise or fall SHALL assert in the same cycle dout takes its new value, for exactly one cycle; they are never both high.
REQ-018 busy SHALL equal (state == QUALIFY), registered.
REQ-019 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the counter SHALL never wrap.
REQ-020 When DEBOUNCE_CYCLES == 1, dout SHALL follow din_s with one edge of delay, and QUALIFY lasts at most one cycle.

Reset
REQ-021 While rst is high, all of the following SHALL be 0 immediately, independent of clk: synchronizer flops, dout, rise, fall, busy, and the counter; the FSM SHALL be in IDLE.
REQ-022 Reset asserted mid-QUALIFY SHALL abort qualification; after release, a din held at 1 SHALL produce dout=1 after DEBOUNCE_CYCLES+2 edges.
REQ-023 Deassertion of rst is not synchronized internally; it SHALL be synchronized upstream.

Configuration
REQ-024 Macro DEBOUNCE_PULSE_EN defined: the rise and fall pulse logic SHALL be built per REQ-017.
REQ-025 Macro DEBOUNCE_PULSE_EN undefined: the rise and fall ports SHALL remain present and be tied to constant 0, with no edge-detect registers built.

Structure
REQ-026 The FSM state enum (IDLE, QUALIFY) SHALL live in shared package debounce_pkg.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module sync_2ff (ports clk, rst, d, q; resets to 0).
REQ-028 All outputs SHALL be registered; no combinational path SHALL exist from din to any output.

Verification (DEBOUNCE_CYCLES=4, DEBOUNCE_PULSE_EN defined unless stated)
REQ-029 Reset held, din=1 -> dout=0, rise=0, busy=0; after release, dout=1 at the 6th edge, with rise high for that one cycle.
REQ-030 din high for 3 cycles then low -> busy pulses high, dout stays 0, and rise never asserts.
REQ-031 din bounces 1,0,1,0, then holds 1 -> dout=1 exactly 6 edges after the final 0->1 transition; no intermediate pulses.
REQ-032 From dout=1, din=0 held -> fall high for one cycle, coincident with dout going 0, 6 edges after the din change.
REQ-033 rst asserted at count 2 of QUALIFY with din=1 -> dout=0 and busy=0 immediately; after release, dout=1 after 6 edges.
REQ-034 Build without DEBOUNCE_PULSE_EN, rerun REQ-031 -> dout timing identical, and rise and fall remain 0 throughout.
